// File: rtl/mips_datapath.sv
// Multicycle 32-bit MIPS-subset CPU with internal 256-byte big-endian RAM.
// Optional feature macro: BRANCH_DELAY_SLOT_EN (delayed branches when defined).
`timescale 1ns/1ps

package mips_pkg;
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_LUI = 3'd6;
endpackage

module mips_reg32 #(
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] Q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            Q <= RESET_VAL;
        else if (en)
            Q <= d;
    end
endmodule

module mips_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] regs [0:31];

    // r0 is never written, so it keeps its reset value of zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (we && wa != 5'd0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];
endmodule

module mips_alu
    import mips_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  shamt,
    input  logic [2:0]  op,
    output logic [31:0] Y
);
    always_comb begin
        Y = A + B;
        case (op)
            ALU_SUB: Y = A - B;
            ALU_AND: Y = A & B;
            ALU_OR:  Y = A | B;
            ALU_SLT: Y = {31'b0, $signed(A) < $signed(B)};
            ALU_SLL: Y = B << shamt;
            ALU_LUI: Y = {B[15:0], 16'h0000};
            default: Y = A + B;
        endcase
    end
endmodule

module mips_ram #(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MOV,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        MOC
);
    localparam int AW = $clog2(MEM_BYTES);

    logic [7:0]    Mem [0:MEM_BYTES-1];
    logic [AW-1:0] a0, a1, a2, a3;
    logic          unused_addr;

    assign a0 = {addr[AW-1:2], 2'b00};
    assign a1 = {addr[AW-1:2], 2'b01};
    assign a2 = {addr[AW-1:2], 2'b10};
    assign a3 = {addr[AW-1:2], 2'b11};
    assign unused_addr = ^{addr[31:AW], addr[1:0]};

    // The whole word is written on one edge, so an aborted access never leaves a partial store
    always_ff @(posedge clk) begin
        if (MOV) begin
            if (we && !rst) begin
                Mem[a0] <= wdata[31:24];
                Mem[a1] <= wdata[23:16];
                Mem[a2] <= wdata[15:8];
                Mem[a3] <= wdata[7:0];
            end
            rdata <= {Mem[a0], Mem[a1], Mem[a2], Mem[a3]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            MOC <= 1'b0;
        else
            MOC <= MOV;
    end
endmodule

module mips_datapath
    import mips_pkg::*;
#(
    parameter int          MEM_BYTES = 256,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic Clear,
    input  logic Clk
);
    localparam logic [3:0] S_RESET = 4'd0,  S_FETCH = 4'd1,   S_FETCH_WAIT = 4'd2,
                           S_DECODE = 4'd3, S_EXEC = 4'd4,    S_WB = 4'd5,
                           S_ADDR = 4'd6,   S_LW_WAIT = 4'd7, S_LW_WB = 4'd8,
                           S_SW_WAIT = 4'd9, S_BRANCH = 4'd10, S_NEXTPC = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                           OP_ADDIU = 6'h09, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_LUI = 6'h0F,
                           OP_LW = 6'h23, OP_SW = 6'h2B;

    logic [3:0]  Y, y_next;
    logic [31:0] pc_q, npc_q, mar_q, ir_q;
    logic [31:0] pc_d, npc_d, mar_d;
    logic        pc_en, npc_en, mar_en, ir_en;
    logic        mov, mem_we, moc;
    logic [31:0] ram_addr, ram_rdata;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd, rd1, rd2;
    logic [31:0] alu_b, alu_y;
    logic [2:0]  alu_op;
    logic        r_ok, use_zext;
    logic [31:0] a_reg, b_reg, alu_out_reg, mdr_reg;
    logic        take_reg;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] sext, zext, target;

    assign op    = ir_q[31:26];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign shamt = ir_q[10:6];
    assign funct = ir_q[5:0];
    assign sext  = {{16{ir_q[15]}}, ir_q[15:0]};
    assign zext  = {16'h0000, ir_q[15:0]};
    // Both targets are relative to nPC, which still holds branch address + 4 here
    assign target = (op == OP_J) ? {npc_q[31:28], ir_q[25:0], 2'b00}
                                 : npc_q + {sext[29:0], 2'b00};

    mips_reg32 #(.RESET_VAL(RESET_PC))         PC  (.clk(Clk), .rst(Clear), .en(pc_en),  .d(pc_d),  .Q(pc_q));
    mips_reg32 #(.RESET_VAL(RESET_PC + 32'd4)) nPC (.clk(Clk), .rst(Clear), .en(npc_en), .d(npc_d), .Q(npc_q));
    mips_reg32 #(.RESET_VAL(32'h0))            MAR (.clk(Clk), .rst(Clear), .en(mar_en), .d(mar_d), .Q(mar_q));
    mips_reg32 #(.RESET_VAL(32'h0))            IR  (.clk(Clk), .rst(Clear), .en(ir_en),  .d(ram_rdata), .Q(ir_q));

    mips_regfile rg (
        .clk(Clk), .rst(Clear), .ra1(rs), .ra2(rt), .rd1(rd1), .rd2(rd2),
        .we(rf_we), .wa(rf_wa), .wd(rf_wd)
    );

    mips_alu ALU (.A(a_reg), .B(alu_b), .shamt(shamt), .op(alu_op), .Y(alu_y));

    // Fetch requests straight from PC so the access overlaps the MAR load
    assign ram_addr = (Y == S_FETCH) ? pc_q : mar_q;

    mips_ram #(.MEM_BYTES(MEM_BYTES)) RAM (
        .clk(Clk), .rst(Clear), .MOV(mov), .we(mem_we), .addr(ram_addr),
        .wdata(b_reg), .rdata(ram_rdata), .MOC(moc)
    );

    always_comb begin
        alu_op   = ALU_ADD;
        r_ok     = 1'b0;
        use_zext = 1'b0;
        case (op)
            OP_RTYPE: begin
                r_ok = 1'b1;
                case (funct)
                    6'h21:   alu_op = ALU_ADD;
                    6'h23:   alu_op = ALU_SUB;
                    6'h24:   alu_op = ALU_AND;
                    6'h25:   alu_op = ALU_OR;
                    6'h2A:   alu_op = ALU_SLT;
                    6'h00:   alu_op = ALU_SLL;
                    default: r_ok = 1'b0;
                endcase
            end
            OP_ANDI: begin alu_op = ALU_AND; use_zext = 1'b1; end
            OP_ORI:  begin alu_op = ALU_OR;  use_zext = 1'b1; end
            OP_LUI:  alu_op = ALU_LUI;
            default: alu_op = ALU_ADD;
        endcase
    end

    assign alu_b = (op == OP_RTYPE) ? b_reg : (use_zext ? zext : sext);

    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear)
            Y <= S_RESET;
        else
            Y <= y_next;
    end

    always_comb begin
        y_next = S_FETCH;
        case (Y)
            S_RESET:      y_next = S_FETCH;
            S_FETCH:      y_next = S_FETCH_WAIT;
            S_FETCH_WAIT: y_next = moc ? S_DECODE : S_FETCH_WAIT;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:                          y_next = r_ok ? S_EXEC : S_NEXTPC;
                    OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI: y_next = S_EXEC;
                    OP_LW, OP_SW:                      y_next = S_ADDR;
                    OP_BEQ, OP_BNE:                    y_next = S_BRANCH;
                    default:                           y_next = S_NEXTPC;
                endcase
            end
            S_EXEC:    y_next = S_WB;
            S_WB:      y_next = S_NEXTPC;
            S_ADDR:    y_next = (op == OP_SW) ? S_SW_WAIT : S_LW_WAIT;
            S_LW_WAIT: y_next = moc ? S_LW_WB : S_LW_WAIT;
            S_LW_WB:   y_next = S_NEXTPC;
            S_SW_WAIT: y_next = moc ? S_NEXTPC : S_SW_WAIT;
            S_BRANCH:  y_next = S_NEXTPC;
            S_NEXTPC:  y_next = S_FETCH;
            default:   y_next = S_FETCH;
        endcase
    end

    always_comb begin
        mov    = 1'b0;
        mem_we = 1'b0;
        mar_en = 1'b0;
        mar_d  = pc_q;
        ir_en  = 1'b0;
        pc_en  = 1'b0;
        npc_en = 1'b0;
        pc_d   = npc_q;
        npc_d  = npc_q + 32'd4;
        rf_we  = 1'b0;
        rf_wa  = rt;
        rf_wd  = alu_out_reg;
        case (Y)
            S_FETCH: begin
                mov    = 1'b1;
                mar_en = 1'b1;
            end
            S_FETCH_WAIT: begin
                mov   = !moc;
                ir_en = moc;
            end
            S_ADDR: begin
                mar_en = 1'b1;
                mar_d  = alu_y;
            end
            S_LW_WAIT: mov = !moc;
            S_SW_WAIT: begin
                mov    = !moc;
                mem_we = 1'b1;
            end
            S_WB: begin
                rf_we = 1'b1;
                rf_wa = (op == OP_RTYPE) ? rd : rt;
            end
            S_LW_WB: begin
                rf_we = 1'b1;
                rf_wd = mdr_reg;
            end
            S_NEXTPC: begin
                pc_en  = 1'b1;
                npc_en = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
                pc_d  = npc_q;
                npc_d = take_reg ? target : npc_q + 32'd4;
`else
                pc_d  = take_reg ? target : npc_q;
                npc_d = take_reg ? target + 32'd4 : npc_q + 32'd4;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            a_reg       <= '0;
            b_reg       <= '0;
            alu_out_reg <= '0;
            mdr_reg     <= '0;
            take_reg    <= 1'b0;
        end else begin
            if (Y == S_DECODE) begin
                a_reg    <= rd1;
                b_reg    <= rd2;
                take_reg <= (op == OP_J);
            end
            if (Y == S_EXEC)
                alu_out_reg <= alu_y;
            if (Y == S_LW_WAIT && moc)
                mdr_reg <= ram_rdata;
            if (Y == S_BRANCH)
                take_reg <= (a_reg == b_reg) ^ (op == OP_BNE);
        end
    end
endmodule

// File: tb/tb_mips_datapath.sv
// Directed program test for mips_datapath; expectations follow BRANCH_DELAY_SLOT_EN.
`timescale 1ns/1ps

module tb_mips_datapath;
    logic Clk = 1'b0;
    logic Clear = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   moc_cycles = 0;
    int   moc_snap = 0;

    mips_datapath #(.MEM_BYTES(256), .RESET_PC(32'h0)) dut (.Clear(Clear), .Clk(Clk));

    always #5 Clk = ~Clk;

    always @(posedge Clk) if (dut.RAM.MOC) moc_cycles++;

    logic [31:0] prog [0:21] = '{
        32'h24010005, // 00 addiu r1,r0,5
        32'h2402FFFD, // 04 addiu r2,r0,-3
        32'h00221821, // 08 addu r3,r1,r2
        32'h0041202A, // 0C slt r4,r2,r1
        32'h00412823, // 10 subu r5,r2,r1
        32'hAC010010, // 14 sw r1,16(r0)
        32'h8C060010, // 18 lw r6,16(r0)
        32'h24000007, // 1C addiu r0,r0,7
        32'h10000002, // 20 beq r0,r0,+2
        32'h24070009, // 24 addiu r7,r0,9 (delay slot)
        32'h24080001, // 28 addiu r8,r0,1 (never runs)
        32'h3429F0F0, // 2C ori r9,r1,0xF0F0
        32'h3C0A1234, // 30 lui r10,0x1234
        32'h304B00FF, // 34 andi r11,r2,0xFF
        32'h00016100, // 38 sll r12,r1,4
        32'h14220001, // 3C bne r1,r2,+1
        32'h240D0003, // 40 addiu r13,r0,3 (delay slot)
        32'h08000014, // 44 j 0x50
        32'h240E0004, // 48 addiu r14,r0,4 (delay slot)
        32'h240F0001, // 4C addiu r15,r0,1 (never runs)
        32'hFC000000, // 50 unknown opcode -> nop
        32'h00000000  // 54 nop
    };

    logic [31:0] exp_pc [$];
    logic [31:0] exp_r  [0:15];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input string tag);
        int n = 0;
        while (dut.Y !== s && n < 60) begin
            @(negedge Clk);
            n++;
        end
        check_val(tag, {28'h0, dut.Y}, {28'h0, s});
    endtask

    function automatic logic [31:0] mem_word(input int a);
        return {dut.RAM.Mem[a], dut.RAM.Mem[a+1], dut.RAM.Mem[a+2], dut.RAM.Mem[a+3]};
    endfunction

    initial begin
`ifdef BRANCH_DELAY_SLOT_EN
        exp_pc = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20,
                   32'h24, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h40, 32'h44, 32'h48,
                   32'h50, 32'h54};
        exp_r = '{32'h0, 32'h5, 32'hFFFFFFFD, 32'h2, 32'h1, 32'hFFFFFFF8, 32'h5, 32'h9,
                  32'h0, 32'hF0F5, 32'h12340000, 32'hFD, 32'h50, 32'h3, 32'h4, 32'h0};
`else
        exp_pc = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20,
                   32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h44, 32'h50, 32'h54};
        exp_r = '{32'h0, 32'h5, 32'hFFFFFFFD, 32'h2, 32'h1, 32'hFFFFFFF8, 32'h5, 32'h0,
                  32'h0, 32'hF0F5, 32'h12340000, 32'hFD, 32'h50, 32'h0, 32'h0, 32'h0};
`endif
        for (int i = 0; i < 22; i++) begin
            dut.RAM.Mem[4*i]   = prog[i][31:24];
            dut.RAM.Mem[4*i+1] = prog[i][23:16];
            dut.RAM.Mem[4*i+2] = prog[i][15:8];
            dut.RAM.Mem[4*i+3] = prog[i][7:0];
        end

        #1 Clear = 1'b1;
        #6;
        check_val("rst_y",   {28'h0, dut.Y}, 32'h0);
        check_val("rst_pc",  dut.PC.Q, 32'h0);
        check_val("rst_npc", dut.nPC.Q, 32'h4);
        check_val("rst_mar", dut.MAR.Q, 32'h0);
        check_val("rst_ir",  dut.IR.Q, 32'h0);
        check_val("rst_moc", {31'h0, dut.RAM.MOC}, 32'h0);
        check_val("rst_r1",  dut.rg.regs[1], 32'h0);
        #4 Clear = 1'b0;

        for (int i = 0; i < exp_pc.size(); i++) begin
            wait_state(4'd1, "reach_fetch");
            check_val($sformatf("pc_%0d", i), dut.PC.Q, exp_pc[i]);
            $display("fetch %0d pc=%08h r1=%08h r6=%08h", i, dut.PC.Q, dut.rg.regs[1], dut.rg.regs[6]);
            if (i == 6) begin
                check_val("sw_moc", moc_cycles - moc_snap, 2);
                check_val("mem16", {24'h0, dut.RAM.Mem[16]}, 32'h00);
                check_val("mem17", {24'h0, dut.RAM.Mem[17]}, 32'h00);
                check_val("mem18", {24'h0, dut.RAM.Mem[18]}, 32'h00);
                check_val("mem19", {24'h0, dut.RAM.Mem[19]}, 32'h05);
            end
            if (i == 7) begin
                check_val("lw_moc", moc_cycles - moc_snap, 2);
                check_val("lw_r6", dut.rg.regs[6], 32'h5);
            end
            moc_snap = moc_cycles;
            @(negedge Clk);
            if (i == 0) begin
                wait_state(4'd3, "reach_decode");
                check_val("ir_first", dut.IR.Q, prog[0]);
            end
        end

        for (int r = 0; r < 16; r++)
            check_val($sformatf("r%0d", r), dut.rg.regs[r], exp_r[r]);

        // Abort an instruction fetch in its wait cycle
        wait_state(4'd2, "reach_fetch_wait");
        #1 Clear = 1'b1;
        #1;
        check_val("abort_y",   {28'h0, dut.Y}, 32'h0);
        check_val("abort_pc",  dut.PC.Q, 32'h0);
        check_val("abort_npc", dut.nPC.Q, 32'h4);
        check_val("abort_moc", {31'h0, dut.RAM.MOC}, 32'h0);
        check_val("abort_r1",  dut.rg.regs[1], 32'h0);
        check_val("abort_m0",  mem_word(0), prog[0]);
        check_val("abort_m16", mem_word(16), 32'h00000005);
        check_val("abort_m84", mem_word(84), prog[21]);
        $display("clear pulse during fetch wait");
        @(negedge Clk);
        Clear = 1'b0;
        wait_state(4'd1, "refetch");
        check_val("refetch_pc", dut.PC.Q, 32'h0);
        @(negedge Clk);
        wait_state(4'd3, "refetch_decode");
        check_val("refetch_ir", dut.IR.Q, prog[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
